pipelined_rca_adder: RTL and testbench
======================================

PIPELINED_RCA_ADDER -- requirements
Module: pipelined_rca_adder

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 41, giving the operand width in bits; legal range 2..128.
REQ-002 The block SHALL provide parameter STAGES, default 4, giving the pipeline depth; legal range 1..WIDTH.
REQ-003 The block SHALL use one clock, i_clk, and one reset, i_rst, which is asynchronous and active-high.
REQ-004 The block SHALL have the following ports, one per line as name, direction, width and meaning:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  asynchronous reset, active-high.
- i_valid  in  1  operands present.
- o_ready  out  1  block can accept operands.
- i_add_term1  in  WIDTH  operand A.
- i_add_term2  in  WIDTH  operand B.
- i_carry  in  1  carry-in, add mode only.
- i_sub  in  1  1 = A-B, 0 = A+B+i_carry.
- o_valid  out  1  result present.
- i_ready  in  1  downstream accepts result.
- o_result  out  WIDTH+1  {carry-out, sum}.
- o_overflow  out  1  two's-complement signed overflow.

Function
REQ-005 The operands SHALL be split LSB-first into STAGES chunks of CHUNK = ceil(WIDTH/STAGES) bits; the last chunk SHALL hold the remaining WIDTH-(STAGES-1)*CHUNK bits, which must be at least 1 (parameters violating this are illegal).
REQ-006 Each pipeline stage SHALL ripple-add exactly one chunk using the carry registered from the previous stage, and SHALL pass the unprocessed upper operand bits and the completed lower sum bits forward in registers.
REQ-007 In add mode, the result SHALL be A + B + i_carry; in sub mode, it SHALL be A + ~B + 1, with i_carry ignored.
REQ-008 o_result[WIDTH] SHALL be the final carry-out; in sub mode, 1 means no borrow (A >= B unsigned).
REQ-009 o_overflow SHALL be (A[MSB] == B'[MSB]) && (sum[MSB] != A[MSB]), where B' is the effective operand (B or ~B).
REQ-010 A transfer in SHALL occur on a rising edge when i_valid && o_ready; a transfer out SHALL occur when o_valid && i_ready.
REQ-011 Latency SHALL be exactly STAGES cycles from the accepting edge to o_valid high, absent stalls.
REQ-012 o_ready SHALL equal !o_valid || i_ready (combinational); when o_ready is 0, every stage register, including valid bits, SHALL hold.
REQ-013 Throughput SHALL be one result per cycle while i_ready is held at 1.
REQ-014 A stage whose valid bit is 0 SHALL carry a bubble; bubbles SHALL advance when not stalled and SHALL NOT be compressed.
REQ-015 o_result and o_overflow SHALL remain stable while o_valid && !i_ready.
REQ-016 Operand changes while i_valid is low SHALL NOT affect any in-flight result.
REQ-017 With STAGES=1, the block SHALL be a single registered full-width adder with 1-cycle latency.

Reset
REQ-018 Asserting i_rst SHALL immediately clear all stage valid bits, o_valid, o_result and o_overflow to 0.
REQ-019 In-flight operations SHALL be discarded on reset mid-operation, and no result for them SHALL ever appear.
REQ-020 o_ready SHALL be 1 while in reset and on the first edge after deassertion.

Verification
REQ-021 The bench SHALL cover: WIDTH=41, STAGES=4, A=0x1FFFFFFFFFF, B=0x1, i_carry=0, i_sub=0, i_ready=1 -> after 4 cycles o_valid=1, o_result=0x20000000000, o_overflow=0.
REQ-022 The bench SHALL cover: A=0x00000000005, B=0x00000000007, i_sub=1 -> o_result[40:0]=0x1FFFFFFFFFE, o_result[41]=0, o_overflow=0.
REQ-023 The bench SHALL cover: A=0x0FFFFFFFFFF, B=0x00000000001, i_sub=0 -> o_result=0x10000000000, o_overflow=1; carry crosses all chunk boundaries.
REQ-024 The bench SHALL cover: 8 back-to-back operations with i_ready=1 -> 8 consecutive o_valid cycles, in order; then i_ready=0 for 3 cycles mid-stream -> o_ready=0, output held, no loss or duplication.
REQ-025 The bench SHALL cover: i_rst pulsed with 3 operations in flight -> o_valid=0 immediately and no stale results afterwards; the first post-reset operation returns after 4 cycles.
REQ-026 The bench SHALL cover: a random regression over STAGES in {1,3,41} and WIDTH in {8,41}, checked against a reference model for result, overflow and ordering.

Source files
------------

// File: rtl/pipelined_rca_adder.sv
// Pipelined ripple-carry adder/subtractor: one operand chunk per stage, carry and
// partial sum travel forward in registers, valid/ready handshake with global stall.
module pipelined_rca_adder #(
    parameter int WIDTH  = 41,
    parameter int STAGES = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add_term1,
    input  logic [WIDTH-1:0] i_add_term2,
    input  logic             i_carry,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_overflow
);
    localparam int CHUNK  = (WIDTH + STAGES - 1) / STAGES;
    localparam int LAST_W = WIDTH - (STAGES - 1) * CHUNK;

    // Per-stage state: remaining operand bits, completed low sum bits, carry, valid.
    logic [WIDTH-1:0] a_reg     [STAGES];
    logic [WIDTH-1:0] b_reg     [STAGES];
    logic [WIDTH-1:0] sum_reg   [STAGES];
    logic             carry_reg [STAGES];
    logic             valid_reg [STAGES];
    logic             ovf_reg;
    logic             advance;

    assign o_valid    = valid_reg[STAGES-1];
    assign o_ready    = !o_valid || i_ready;
    assign advance    = o_ready;
    assign o_result   = {carry_reg[STAGES-1], sum_reg[STAGES-1]};
    assign o_overflow = ovf_reg;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        localparam int LO = gi * CHUNK;
        localparam int W  = (gi == STAGES - 1) ? LAST_W : CHUNK;

        logic [WIDTH-1:0] a_in;
        logic [WIDTH-1:0] b_in;
        logic [WIDTH-1:0] sum_in;
        logic [WIDTH-1:0] a_next;
        logic [WIDTH-1:0] b_next;
        logic [WIDTH-1:0] sum_next;
        logic             c_in;
        logic             v_in;
        logic [W-1:0]     chunk_sum;
        logic             ripple;
        logic             c_out;

        if (gi == 0) begin : g_head
            // Subtraction is A + ~B + 1; the carry-in is forced and i_carry ignored.
            assign a_in   = i_add_term1;
            assign b_in   = i_sub ? ~i_add_term2 : i_add_term2;
            assign c_in   = i_sub | i_carry;
            assign sum_in = '0;
            assign v_in   = i_valid;
        end else begin : g_body
            assign a_in   = a_reg[gi-1];
            assign b_in   = b_reg[gi-1];
            assign c_in   = carry_reg[gi-1];
            assign sum_in = sum_reg[gi-1];
            assign v_in   = valid_reg[gi-1];
        end

        always_comb begin
            ripple    = c_in;
            chunk_sum = '0;
            for (int k = 0; k < W; k++) begin
                chunk_sum[k] = a_in[LO + k] ^ b_in[LO + k] ^ ripple;
                ripple       = (a_in[LO + k] & b_in[LO + k]) |
                               (ripple & (a_in[LO + k] ^ b_in[LO + k]));
            end
            c_out = ripple;
        end

        always_comb begin
            sum_next            = sum_in;
            sum_next[LO +: W]   = chunk_sum;
            a_next              = a_in;
            a_next[LO +: W]     = '0;
            b_next              = b_in;
            b_next[LO +: W]     = '0;
        end

        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                valid_reg[gi] <= 1'b0;
                carry_reg[gi] <= 1'b0;
                a_reg[gi]     <= '0;
                b_reg[gi]     <= '0;
                sum_reg[gi]   <= '0;
            end else if (advance) begin
                valid_reg[gi] <= v_in;
                carry_reg[gi] <= c_out;
                a_reg[gi]     <= a_next;
                b_reg[gi]     <= b_next;
                sum_reg[gi]   <= sum_next;
            end
        end

        // The final chunk holds the sign bits, so signed overflow is resolved here.
        if (gi == STAGES - 1) begin : g_ovf
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    ovf_reg <= 1'b0;
                end else if (advance) begin
                    ovf_reg <= (a_in[WIDTH-1] == b_in[WIDTH-1]) &&
                               (chunk_sum[W-1] != a_in[WIDTH-1]);
                end
            end
        end
    end

endmodule

// File: tb/tb_pipelined_rca_adder.sv
// Self-checking bench: directed vector table, stall/reset sequences and random
// regression on several WIDTH/STAGES builds against an arithmetic reference model.
module tb_pipelined_rca_adder;
    localparam int NI = 6;
    localparam int WS [NI] = '{41, 8, 8, 41, 41, 41};
    localparam int SS [NI] = '{4, 1, 3, 1, 3, 41};

    logic         clk = 1'b0;
    logic         trst  [NI];
    logic         tv    [NI];
    logic         trdy  [NI];
    logic         tcin  [NI];
    logic         tsub  [NI];
    logic [127:0] ta1   [NI];
    logic [127:0] ta2   [NI];
    wire          tordy [NI];
    wire          tov   [NI];
    wire          tovf  [NI];
    wire  [128:0] tres  [NI];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int W = WS[gi];
        logic [W:0] res_w;
        pipelined_rca_adder #(.WIDTH(W), .STAGES(SS[gi])) u_dut (
            .i_clk       (clk),
            .i_rst       (trst[gi]),
            .i_valid     (tv[gi]),
            .o_ready     (tordy[gi]),
            .i_add_term1 (ta1[gi][W-1:0]),
            .i_add_term2 (ta2[gi][W-1:0]),
            .i_carry     (tcin[gi]),
            .i_sub       (tsub[gi]),
            .o_valid     (tov[gi]),
            .i_ready     (trdy[gi]),
            .o_result    (res_w),
            .o_overflow  (tovf[gi])
        );
        assign tres[gi] = {{(128 - W){1'b0}}, res_w};
    end

    typedef struct {
        logic [127:0] a;
        logic [127:0] b;
        logic         cin;
        logic         sub;
        logic [128:0] res;
        logic         ovf;
        string        nm;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input logic [129:0] act, input logic [129:0] exp, input string nm);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd(input int w);
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r & ((128'(1) << w) - 128'(1));
    endfunction

    // Reference: plain integer arithmetic on the effective operands.
    function automatic logic [129:0] model(input int w, input logic [127:0] a, input logic [127:0] b,
                                           input logic cin, input logic sub);
        logic [128:0] mask;
        logic [128:0] bb;
        logic [128:0] tot;
        logic         ovf;
        mask = (129'(1) << w) - 129'(1);
        bb   = sub ? (~{1'b0, b}) & mask : {1'b0, b};
        tot  = {1'b0, a} + bb + (sub ? 129'(1) : 129'(cin));
        tot  = tot & ((mask << 1) | 129'(1));
        ovf  = (a[w-1] == bb[w-1]) && (tot[w-1] != a[w-1]);
        return {ovf, tot};
    endfunction

    task automatic run_one(input int k, input vec_t v);
        int lat;
        @(negedge clk);
        ta1[k] = v.a; ta2[k] = v.b; tcin[k] = v.cin; tsub[k] = v.sub;
        tv[k] = 1'b1; trdy[k] = 1'b1;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        // Operands wander while idle; the in-flight result must not notice.
        tv[k] = 1'b0; ta1[k] = rnd(WS[k]); ta2[k] = rnd(WS[k]);
        tcin[k] = 1'($urandom); tsub[k] = 1'($urandom);
        while (!tov[k] && lat < 60) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk(130'(lat), 130'(SS[k]), {v.nm, "_latency"});
        chk(130'(tres[k]), 130'(v.res), {v.nm, "_result"});
        chk(130'(tovf[k]), 130'(v.ovf), {v.nm, "_overflow"});
    endtask

    // mode 0: back-to-back, ready=1; mode 1: random valid/ready; mode 2: back-to-back with 3-cycle stall.
    task automatic traffic(input int k, input int n_ops, input int mode,
                           output int max_run, output int stalls);
        logic [129:0] q[$];
        logic [129:0] exp;
        logic [129:0] held;
        logic         prev_hold;
        logic         vld;
        logic         rdy;
        int           sent;
        int           cyc;
        int           run;
        sent = 0; cyc = 0; run = 0; max_run = 0; stalls = 0;
        prev_hold = 1'b0; held = '0;
        while ((sent < n_ops || q.size() > 0) && cyc < 4000) begin
            @(negedge clk);
            vld = (sent < n_ops) && ((mode != 1) || ($urandom_range(0, 3) != 0));
            rdy = (mode == 1) ? ($urandom_range(0, 3) != 0) : !(mode == 2 && cyc >= 6 && cyc < 9);
            tv[k] = vld; trdy[k] = rdy;
            ta1[k] = rnd(WS[k]); ta2[k] = rnd(WS[k]);
            tcin[k] = 1'($urandom); tsub[k] = 1'($urandom);
            #1;
            if (prev_hold) chk({tovf[k], tres[k]} | 130'(!tov[k]) << 129, held, "stall_hold");
            if (tov[k] && !rdy) begin
                stalls++;
                chk(130'(tordy[k]), 130'(0), "stall_ready");
            end
            if (tov[k]) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
            if (tov[k] && rdy) begin
                if (q.size() == 0) begin
                    chk(130'(1), 130'(0), "unexpected_result");
                end else begin
                    exp = q.pop_front();
                    chk({tovf[k], tres[k]}, exp, $sformatf("inst%0d_result", k));
                end
            end
            if (vld && tordy[k]) begin
                q.push_back(model(WS[k], ta1[k], ta2[k], tcin[k], tsub[k]));
                sent++;
            end
            prev_hold = tov[k] && !rdy;
            held = {tovf[k], tres[k]};
            cyc++;
        end
        if (sent < n_ops || q.size() > 0) chk(130'(q.size()), 130'(0), "traffic_timeout");
        @(negedge clk);
        tv[k] = 1'b0; trdy[k] = 1'b1;
    endtask

    initial begin
        int mr;
        int sc;
        int stale;
        vec_t v;

        tbl[0] = '{a:128'h1FFFFFFFFFF, b:128'h1,           cin:1'b0, sub:1'b0, res:129'h20000000000, ovf:1'b0, nm:"carry_all"};
        tbl[1] = '{a:128'h5,           b:128'h7,           cin:1'b0, sub:1'b1, res:129'h1FFFFFFFFFE, ovf:1'b0, nm:"sub_borrow"};
        tbl[2] = '{a:128'h0FFFFFFFFFF, b:128'h1,           cin:1'b0, sub:1'b0, res:129'h10000000000, ovf:1'b1, nm:"pos_ovf"};
        tbl[3] = '{a:128'h0FFFFFFFFFF, b:128'h0,           cin:1'b1, sub:1'b0, res:129'h10000000000, ovf:1'b1, nm:"cin_ovf"};
        tbl[4] = '{a:128'h123,         b:128'h123,         cin:1'b1, sub:1'b1, res:129'h20000000000, ovf:1'b0, nm:"sub_equal"};
        tbl[5] = '{a:128'h10000000000, b:128'h1,           cin:1'b0, sub:1'b1, res:129'h2FFFFFFFFFF, ovf:1'b1, nm:"neg_ovf_sub"};
        tbl[6] = '{a:128'h1FFFFFFFFFF, b:128'h1FFFFFFFFFF, cin:1'b1, sub:1'b0, res:129'h3FFFFFFFFFF, ovf:1'b0, nm:"neg_add"};
        tbl[7] = '{a:128'h7FF,         b:128'h1,           cin:1'b0, sub:1'b0, res:129'h800,         ovf:1'b0, nm:"chunk_edge"};

        for (int k = 0; k < NI; k++) begin
            trst[k] = 1'b1; tv[k] = 1'b0; trdy[k] = 1'b1;
            tcin[k] = 1'b0; tsub[k] = 1'b0; ta1[k] = '0; ta2[k] = '0;
        end
        repeat (2) @(negedge clk);
        chk(130'(tov[0]), 130'(0), "reset_valid");
        chk(130'(tres[0]), 130'(0), "reset_result");
        chk(130'(tovf[0]), 130'(0), "reset_overflow");
        chk(130'(tordy[0]), 130'(1), "reset_ready");
        for (int k = 0; k < NI; k++) trst[k] = 1'b0;

        for (int i = 0; i < 8; i++) run_one(0, tbl[i]);

        traffic(0, 8, 0, mr, sc);
        chk(130'(mr), 130'(8), "b2b_consecutive");
        traffic(0, 8, 2, mr, sc);
        chk(130'(sc), 130'(3), "stall_cycles");

        // Reset with three operations in flight, the oldest already at the output.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tv[0] = 1'b1; trdy[0] = 1'b1; ta1[0] = rnd(41); ta2[0] = rnd(41);
        end
        @(negedge clk);
        tv[0] = 1'b0;
        @(negedge clk);
        trdy[0] = 1'b0;
        #1;
        chk(130'(tov[0]), 130'(1), "rst_pre_valid");
        trst[0] = 1'b1;
        #1;
        chk(130'(tov[0]), 130'(0), "rst_valid_clear");
        chk(130'(tres[0]), 130'(0), "rst_result_clear");
        chk(130'(tovf[0]), 130'(0), "rst_ovf_clear");
        chk(130'(tordy[0]), 130'(1), "rst_ready");
        repeat (2) @(negedge clk);
        trdy[0] = 1'b1;
        trst[0] = 1'b0;
        #1;
        chk(130'(tordy[0]), 130'(1), "post_rst_ready");
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (tov[0]) stale++;
        end
        chk(130'(stale), 130'(0), "no_stale_results");
        v = tbl[0];
        v.nm = "post_rst_op";
        run_one(0, v);

        for (int k = 0; k < NI; k++) traffic(k, 150, 1, mr, sc);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
